// File: rtl/clk_div_pkg.sv
// Shared types and constants for the counter-board clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } state_t;

    localparam int SYS_HZ  = 50_000_000;
    localparam int DIV_1K  = 24999;     // 50 MHz / (2 * 25000) = 1 kHz level
    localparam int DIV_25M = 1;         // 50 MHz / (2 * 2)     = 12.5 MHz level, 25 MHz tick

    // Counter width needed to hold a divisor; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div < 1) ? 1 : $clog2(div + 1);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// One divider channel: loadable down-counter with registered tick and level.
// Priority is clear > load > count. The reload value is sampled at every
// terminal count, so the controller can swap it exactly at a period boundary.
module clk_div_core #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         term,
    output logic         tick,
    output logic         level
);

    logic [W-1:0] cnt;

    // Terminal count is visible before the edge so the controller can act on it.
    assign term = (cnt == '0);

    // Count down, pulse tick and toggle level on terminal count, then reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (en) begin
            if (term) begin
                cnt   <= load_val;
                tick  <= 1'b1;
                level <= ~level;
            end else begin
                cnt   <= cnt - 1'b1;
                tick  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and configuration controller for the slow (programmable) and fast
// (fixed) divider channels. A divisor accepted while running is parked in
// pend_reg and only takes effect at the next slow terminal count, so downstream
// never sees a truncated period.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 15,
    parameter int DEFAULT_DIV = DIV_1K,
    parameter int FAST_DIV    = DIV_25M
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             running,
    output logic             slow_tick,
    output logic             slow_level,
    output logic             fast_tick,
    output logic             fast_level
);

    localparam int FAST_W = cnt_width(FAST_DIV);

    state_t           state, next_state;
    logic [DIV_W-1:0] div_reg, pend_reg, slow_load_val;
    logic             xfer;
    logic             ch_load, ch_en, ch_clr;
    logic             slow_term;
    logic             fast_term_unused;

    assign cfg_ready = (state != RUN_PEND);
    assign running   = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    // Channels are held cleared whenever they are neither starting nor counting.
    assign ch_clr    = !(ch_load || ch_en);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and channel controls; stop always wins over start.
    always_comb begin
        next_state    = state;
        ch_load       = 1'b0;
        ch_en         = 1'b0;
        slow_load_val = div_reg;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state = RUN;
                    ch_load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else begin
                    ch_en = 1'b1;
                    if (xfer) next_state = RUN_PEND;
                end
            end
            RUN_PEND: begin
                // Reload with the pending divisor so the new period starts
                // exactly at this terminal count.
                slow_load_val = pend_reg;
                if (stop) begin
                    next_state = IDLE;
                end else begin
                    ch_en = 1'b1;
                    if (slow_term) next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Divisor registers: direct write when idle, staged while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= DIV_W'(DEFAULT_DIV);
            pend_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) div_reg <= cfg_div;
                end
                RUN: begin
                    // A config accepted on the same edge as stop goes straight
                    // to div_reg so it is not lost.
                    if (xfer) begin
                        if (stop) div_reg  <= cfg_div;
                        else      pend_reg <= cfg_div;
                    end
                end
                RUN_PEND: begin
                    if (stop || slow_term) div_reg <= pend_reg;
                end
                default: ;
            endcase
        end
    end

    clk_div_core #(.W(DIV_W)) u_slow (
        .clk      (clk),
        .reset    (reset),
        .clr      (ch_clr),
        .load     (ch_load),
        .en       (ch_en),
        .load_val (slow_load_val),
        .term     (slow_term),
        .tick     (slow_tick),
        .level    (slow_level)
    );

    clk_div_core #(.W(FAST_W)) u_fast (
        .clk      (clk),
        .reset    (reset),
        .clr      (ch_clr),
        .load     (ch_load),
        .en       (ch_en),
        .load_val (FAST_W'(FAST_DIV)),
        .term     (fast_term_unused),
        .tick     (fast_tick),
        .level    (fast_level)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start/stop, staged reconfiguration,
// divisor 0 and asynchronous reset, with hand-computed tick spacing.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, cfg_valid;
    logic [14:0] cfg_div;
    logic        cfg_ready, running, slow_tick, slow_level, fast_tick, fast_level;

    int n_checks = 0;
    int n_errors = 0;
    int g;

    clk_div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .running    (running),
        .slow_tick  (slow_tick),
        .slow_level (slow_level),
        .fast_tick  (fast_tick),
        .fast_level (fast_level)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until the chosen tick is seen; -1 if it never comes.
    task automatic gap(input bit fast, output int n);
        n = -1;
        for (int i = 1; i <= 30000; i++) begin
            step();
            if (fast ? fast_tick : slow_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic cfg(input int d);
        cfg_valid = 1'b1;
        cfg_div   = 15'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #5;
        chk("rst_running",    running,    0);
        chk("rst_cfg_ready",  cfg_ready,  1);
        chk("rst_slow_tick",  slow_tick,  0);
        chk("rst_slow_level", slow_level, 0);
        chk("rst_fast_tick",  fast_tick,  0);
        chk("rst_fast_level", fast_level, 0);
        step(); step();
        reset = 1'b0;

        // Div 3 set in IDLE, then start.
        cfg(3);
        start = 1'b1; step(); start = 1'b0;
        chk("start_running", running, 1);
        chk("start_tick0",   slow_tick, 0);
        gap(0, g); chk("first_gap_d3", g, 4);
        chk("lvl_after_1", slow_level, 1);
        gap(0, g); chk("gap_d3", g, 4);
        chk("lvl_after_2", slow_level, 0);
        gap(1, g); chk("fast_gap_a", g, 2);
        chk("fast_lvl_a", fast_level, 1);
        gap(1, g); chk("fast_gap_b", g, 2);
        chk("fast_lvl_b", fast_level, 0);
        chk("slow_tick_e12", slow_tick, 1);

        // Mid-period reconfigure to 5.
        step();
        cfg_valid = 1'b1; cfg_div = 15'd5;
        chk("ready_before_xfer", cfg_ready, 1);
        step(); cfg_valid = 1'b0;
        chk("ready_pend", cfg_ready, 0);
        gap(0, g); chk("old_period_completes", g, 2);
        chk("ready_back", cfg_ready, 1);
        gap(0, g); chk("new_gap_d5_a", g, 6);
        gap(0, g); chk("new_gap_d5_b", g, 6);

        // Stop, then transfer coincident with terminal count at div 3.
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_running",   running,   0);
        chk("stop_slow_tick", slow_tick, 0);
        cfg(3);
        start = 1'b1; step(); start = 1'b0;
        gap(0, g); chk("restart_gap_d3", g, 4);
        step(); step(); step();
        cfg_valid = 1'b1; cfg_div = 15'd7;
        step(); cfg_valid = 1'b0;
        chk("coinc_tick",  slow_tick, 1);
        chk("coinc_ready", cfg_ready, 0);
        gap(0, g); chk("coinc_old_gap", g, 4);
        gap(0, g); chk("coinc_new_gap", g, 8);

        // start+stop in IDLE stays idle.
        stop = 1'b1; step();
        start = 1'b1; step();
        chk("ss_idle_running", running, 0);
        stop = 1'b0; step(); start = 1'b0;
        gap(0, g); chk("d7_gap", g, 8);

        // start+stop in RUN_PEND commits the pending divisor.
        cfg(2);
        chk("pend_ready", cfg_ready, 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("ss_pend_running",   running,    0);
        chk("ss_pend_slow_tick", slow_tick,  0);
        chk("ss_pend_fast_lvl",  fast_level, 0);
        start = 1'b1; step(); start = 1'b0;
        gap(0, g); chk("committed_gap_d2", g, 3);

        // Divisor 0: tick every cycle.
        stop = 1'b1; step(); stop = 1'b0;
        cfg(0);
        start = 1'b1; step(); start = 1'b0;
        chk("d0_start_tick", slow_tick, 0);
        step();
        chk("d0_tick_a", slow_tick,  1);
        chk("d0_lvl_a",  slow_level, 1);
        step();
        chk("d0_tick_b", slow_tick,  1);
        chk("d0_lvl_b",  slow_level, 0);

        // Asynchronous reset in RUN_PEND.
        stop = 1'b1; step(); stop = 1'b0;
        cfg(5);
        start = 1'b1; step(); start = 1'b0;
        gap(0, g); chk("d5_gap", g, 6);
        chk("d5_lvl", slow_level, 1);
        cfg(9);
        chk("rp_ready", cfg_ready, 0);
        step();
        #3 reset = 1'b1;
        #1;
        chk("arst_running",    running,    0);
        chk("arst_cfg_ready",  cfg_ready,  1);
        chk("arst_slow_level", slow_level, 0);
        chk("arst_slow_tick",  slow_tick,  0);
        chk("arst_fast_tick",  fast_tick,  0);
        step();
        reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        gap(0, g); chk("default_gap", g, 25000);
        chk("default_lvl", slow_level, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
